pipe_mem_resp: RTL

- MEM stage of the 5-stage LoongArch pipeline, directly downstream of EX and upstream of WB.
- Accepts EX results under the valid/allowin handshake.
- For loads whose SRAM-like request EX already issued (addr_ok seen), waits for the data_ok response, buffers rdata if WB stalls, and performs byte/halfword extraction and sign/zero extension.
- Produces the final register write-back value, plus forwarding/blocking info for ID.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/mem_load_ext.sv | 53 +++++
 rtl/pipe_mem_resp.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the LoongArch pipeline stages.
// Load-op one-hot bit positions and default widths.
package pipe_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int RF_AW_DEF = 5;

  localparam int LD_B  = 0;
  localparam int LD_H  = 1;
  localparam int LD_W  = 2;
  localparam int LD_BU = 3;
  localparam int LD_HU = 4;

  localparam int LOAD_OP_W = 5;

  typedef logic [LOAD_OP_W-1:0] load_op_t;

endpackage

// File: rtl/mem_load_ext.sv
// Load data lane selection and sign/zero extension.
// Purely combinational; addr picks the byte or halfword lane.
module mem_load_ext
  import pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] i_raw,
  input  logic [1:0]      i_addr,
  input  logic [4:0]      i_load_op,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // byte lane chosen by the two low address bits
  always_comb begin
    w_byte = i_raw[7:0];
    case (i_addr)
      2'b00: w_byte = i_raw[7:0];
      2'b01: w_byte = i_raw[15:8];
      2'b10: w_byte = i_raw[23:16];
      2'b11: w_byte = i_raw[31:24];
      default: w_byte = i_raw[7:0];
    endcase
  end

  // halfword lane chosen by address bit 1
  always_comb begin
    w_half = i_addr[1] ? i_raw[31:16] : i_raw[15:0];
  end

  // extend according to the one-hot load kind
  always_comb begin
    o_data = '0;
    unique case (1'b1)
      i_load_op[LD_B]:
        o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      i_load_op[LD_H]:
        o_data = {{(XLEN-16){w_half[15]}}, w_half};
      i_load_op[LD_W]:
        o_data = i_raw;
      i_load_op[LD_BU]:
        o_data = {{(XLEN-8){1'b0}}, w_byte};
      i_load_op[LD_HU]:
        o_data = {{(XLEN-16){1'b0}}, w_half};
      default:
        o_data = '0;
    endcase
  end

endmodule

// File: rtl/pipe_mem_resp.sv
// MEM stage: waits for the data response of an issued load,
// buffers it across WB stalls and forms the write-back value.
module pipe_mem_resp
  import pipe_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RF_AW = RF_AW_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             from_valid,
  input  logic             from_allowin,
  input  logic [XLEN-1:0]  from_pc,
  input  logic [XLEN-1:0]  alu_result_EX,
  input  logic             rf_we_EX,
  input  logic [RF_AW-1:0] rf_waddr_EX,
  input  logic             res_from_mem_EX,
  input  logic [4:0]       load_op_EX,
  input  logic             mem_issued_EX,
  input  logic             data_sram_data_ok,
  input  logic [XLEN-1:0]  data_sram_rdata,
  output logic             to_allowin,
  output logic             to_valid,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic [XLEN-1:0]  PC,
  output logic             fwd_block
);

  logic             r_valid;
  logic             r_pending;
  logic             r_buf_valid;
  logic [XLEN-1:0]  r_pc;
  logic             r_rf_we;
  logic [RF_AW-1:0] r_rf_waddr;
  logic             r_res_from_mem;
  logic [4:0]       r_load_op;
  logic [XLEN-1:0]  r_alu_result;
  logic [XLEN-1:0]  r_rdata_buf;

  logic             w_ready_go;
  logic             w_to_allowin;
  logic             w_to_valid;
  logic             w_entry;
  logic             w_advance;
  logic             w_capture;
  logic [XLEN-1:0]  w_raw;
  logic [XLEN-1:0]  w_load_data;

  // a load is ready once its data is on the port or buffered
  assign w_ready_go = r_valid
                    & (~r_pending
                       | data_sram_data_ok
                       | r_buf_valid);

  assign w_to_allowin = ~r_valid
                      | (w_ready_go & from_allowin);
  assign w_to_valid   = r_valid & w_ready_go;
  assign w_entry      = from_valid & w_to_allowin;
  assign w_advance    = w_to_valid & from_allowin;

  // response arrived but WB is stalled: park it
  assign w_capture = r_valid & r_pending
                   & data_sram_data_ok
                   & ~w_advance;

  // stage occupancy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= 1'b0;
    end else if (w_to_allowin) begin
      r_valid <= from_valid;
    end
  end

  // outstanding-response and buffer tracking
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pending   <= 1'b0;
      r_buf_valid <= 1'b0;
    end else if (w_entry) begin
      r_pending   <= mem_issued_EX;
      r_buf_valid <= 1'b0;
    end else if (w_advance) begin
      r_pending   <= 1'b0;
      r_buf_valid <= 1'b0;
    end else if (w_capture) begin
      r_pending   <= 1'b0;
      r_buf_valid <= 1'b1;
    end
  end

  // holding register for response data during a WB stall
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rdata_buf <= '0;
    end else if (w_capture) begin
      r_rdata_buf <= data_sram_rdata;
    end
  end

  // instruction payload from EX
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pc           <= '0;
      r_rf_we        <= 1'b0;
      r_rf_waddr     <= '0;
      r_res_from_mem <= 1'b0;
      r_load_op      <= '0;
      r_alu_result   <= '0;
    end else if (w_entry) begin
      r_pc           <= from_pc;
      r_rf_we        <= rf_we_EX;
      r_rf_waddr     <= rf_waddr_EX;
      r_res_from_mem <= res_from_mem_EX;
      r_load_op      <= load_op_EX;
      r_alu_result   <= alu_result_EX;
    end
  end

  assign w_raw = r_buf_valid ? r_rdata_buf
                             : data_sram_rdata;

  mem_load_ext #(
    .XLEN (XLEN)
  ) u_load_ext (
    .i_raw     (w_raw),
    .i_addr    (r_alu_result[1:0]),
    .i_load_op (r_load_op),
    .o_data    (w_load_data)
  );

  assign to_allowin = w_to_allowin;
  assign to_valid   = w_to_valid;
  assign rf_we      = r_rf_we;
  assign rf_waddr   = r_rf_waddr;
  assign PC         = r_pc;
  assign rf_wdata   = r_res_from_mem ? w_load_data
                                     : r_alu_result;
  assign fwd_block  = r_valid & r_res_from_mem
                    & ~w_ready_go;

endmodule
